// File: rtl/iomem_router.sv
// Routes one picorv32-style iomem transaction at a time to one of NUM_SLAVES channels
// using base/mask decode, with a per-transaction timeout and an error status register.
module iomem_router #(
  parameter int                         NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE       = {32'h0303_0000, 32'h0302_0000,
                                                          32'h0301_0000, 32'h0300_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK       = {4{32'hFFFF_0000}},
  parameter int                         TIMEOUT_CYCLES = 256,
  parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF,
  parameter logic [31:0]                STATUS_ADDR    = 32'h0400_0000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    slv_valid,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  input  logic [NUM_SLAVES*32-1:0] slv_rdata,
  output logic [31:0]              slv_addr,
  output logic [31:0]              slv_wdata,
  output logic [3:0]               slv_wstrb,
  output logic                     err_irq
);

  localparam int          SELW       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP
  } state_t;

  state_t                r_state;
  logic [SELW-1:0]       r_sel;
  logic [15:0]           r_timer;
  logic [15:0]           r_err_count;
  logic [31:0]           r_last_err_addr;
  logic [31:0]           r_mem_rdata;
  logic                  r_mem_ready;
  logic [NUM_SLAVES-1:0] r_slv_valid;

  logic                  w_hit;
  logic [SELW-1:0]       w_sel;
  logic                  w_is_status;
  logic [15:0]           w_err_count_inc;
  logic [31:0]           w_rdata_arr [NUM_SLAVES];

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rdata
    assign w_rdata_arr[g] = slv_rdata[32*g +: 32];
  end

  // Scan from the top index down so the lowest matching channel is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        w_hit = 1'b1;
        w_sel = SELW'(i);
      end
    end
  end

  assign w_is_status     = (mem_addr == STATUS_ADDR);
  assign w_err_count_inc = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;

  // r_mem_ready gates IDLE so the request just completed is not re-accepted while mem_valid lingers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= ST_IDLE;
      r_sel           <= '0;
      r_timer         <= '0;
      r_err_count     <= '0;
      r_last_err_addr <= '0;
      r_mem_rdata     <= '0;
      r_mem_ready     <= 1'b0;
      r_slv_valid     <= '0;
    end else begin
      r_mem_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (mem_valid && !r_mem_ready) begin
            if (w_is_status) begin
              r_state <= ST_RESP;
              if (mem_wstrb != 4'b0000) begin
                r_err_count     <= '0;
                r_last_err_addr <= '0;
                r_mem_rdata     <= '0;
              end else begin
                r_mem_rdata <= {r_last_err_addr[31:16], r_err_count};
              end
            end else if (w_hit) begin
              r_sel       <= w_sel;
              r_slv_valid <= NUM_SLAVES'(1) << w_sel;
              r_state     <= ST_ACTIVE;
            end else begin
              r_mem_rdata     <= ERR_RDATA;
              r_err_count     <= w_err_count_inc;
              r_last_err_addr <= mem_addr;
              r_state         <= ST_RESP;
            end
          end
        end

        ST_ACTIVE: begin
          if (!mem_valid) begin
            r_slv_valid <= '0;
            r_timer     <= '0;
            r_state     <= ST_IDLE;
          end else if (slv_ready[r_sel]) begin
            r_mem_rdata <= w_rdata_arr[r_sel];
            r_slv_valid <= '0;
            r_state     <= ST_RESP;
          end else if (r_timer == TIMER_LAST) begin
            r_slv_valid     <= '0;
            r_mem_rdata     <= ERR_RDATA;
            r_err_count     <= w_err_count_inc;
            r_last_err_addr <= mem_addr;
            r_state         <= ST_RESP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        ST_RESP: begin
          r_mem_ready <= 1'b1;
          r_timer     <= '0;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_slv_valid <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;
  assign slv_valid = r_slv_valid;
  assign slv_addr  = mem_addr;
  assign slv_wdata = mem_wdata;
  assign slv_wstrb = mem_wstrb;
  assign err_irq   = (r_err_count != 16'd0);

endmodule

// File: tb/tb_iomem_router.sv
// Directed bench for iomem_router: slave routing, overlap priority, unmapped/timeout errors,
// status register read/clear, abort and asynchronous reset.
module tb_iomem_router;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         mem_valid = 1'b0;
  logic         mem_ready;
  logic [31:0]  mem_addr = '0;
  logic [31:0]  mem_wdata = '0;
  logic [3:0]   mem_wstrb = '0;
  logic [31:0]  mem_rdata;
  logic [3:0]   slv_valid;
  logic [3:0]   slv_ready = '0;
  logic [127:0] slv_rdata = '0;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_wstrb;
  logic         err_irq;

  int checks = 0;
  int failures = 0;

  logic [31:0] gotRdata;
  int          gotLat;
  int          validCount;
  logic [3:0]  validOr;

  always #5 clk = ~clk;

  // Channel 3 is a wide 0x03xx_xxxx window overlapping channels 0..2, so lower indices must win.
  iomem_router #(
    .NUM_SLAVES    (4),
    .SLV_BASE      ({32'h0300_0000, 32'h0302_0000, 32'h0301_0000, 32'h0300_0000}),
    .SLV_MASK      ({32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA     (32'hDEAD_BEEF),
    .STATUS_ADDR   (32'h0400_0000)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .slv_valid(slv_valid),
    .slv_ready(slv_ready),
    .slv_rdata(slv_rdata),
    .slv_addr (slv_addr),
    .slv_wdata(slv_wdata),
    .slv_wstrb(slv_wstrb),
    .err_irq  (err_irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one CPU access and plays the selected slave, which raises ready on its
  // (delay+1)-th observed slv_valid cycle; stray bits drive ready on other channels.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int chan, input int delay,
                               input logic [31:0] rdata, input logic [3:0] stray);
    bit done;
    done       = 1'b0;
    gotRdata   = '0;
    gotLat     = 0;
    validCount = 0;
    validOr    = '0;
    slv_rdata  = '0;
    slv_rdata[32*chan +: 32] = rdata;
    mem_addr   = addr;
    mem_wdata  = wdata;
    mem_wstrb  = wstrb;
    slv_ready  = stray;
    mem_valid  = 1'b1;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      if (mem_ready) begin
        gotRdata = mem_rdata;
        gotLat   = cyc;
        done     = 1'b1;
      end else begin
        slv_ready = stray;
        if (slv_valid != 4'b0000) begin
          validCount++;
          validOr |= slv_valid;
        end
        if (slv_valid[chan] && validCount == delay + 1) slv_ready[chan] = 1'b1;
      end
    end
    mem_valid = 1'b0;
    slv_ready = '0;
    checkOutput("readyWait", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("readyPulse", 32'(mem_ready), 32'd0);
  endtask

  task automatic readStatus(input string tag, input logic [31:0] expected);
    applyStimulus(32'h0400_0000, 32'h0, 4'h0, 0, 100, 32'h0, 4'h0);
    checkOutput(tag, gotRdata, expected);
    checkOutput({tag, "Lat"}, 32'(gotLat), 32'd2);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rstReady", 32'(mem_ready), 32'd0);
    checkOutput("rstRdata", mem_rdata, 32'h0);
    checkOutput("rstValid", 32'(slv_valid), 32'h0);
    checkOutput("rstIrq", 32'(err_irq), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    applyStimulus(32'h0301_0010, 32'h0, 4'h0, 1, 3, 32'h1234_5678, 4'h0);
    checkOutput("rdCh1Data", gotRdata, 32'h1234_5678);
    checkOutput("rdCh1Lat", 32'(gotLat), 32'd6);
    checkOutput("rdCh1ValidCnt", 32'(validCount), 32'd4);
    checkOutput("rdCh1ValidOr", 32'(validOr), 32'h2);

    applyStimulus(32'h0300_0000, 32'hA5A5_A5A5, 4'hF, 0, 0, 32'h0, 4'h0);
    checkOutput("wrCh0Lat", 32'(gotLat), 32'd3);
    checkOutput("wrCh0ValidOr", 32'(validOr), 32'h1);
    checkOutput("wrCh0Wdata", slv_wdata, 32'hA5A5_A5A5);
    checkOutput("wrCh0Wstrb", 32'(slv_wstrb), 32'hF);
    checkOutput("wrCh0Addr", slv_addr, 32'h0300_0000);

    applyStimulus(32'h0300_1234, 32'h0, 4'h0, 0, 1, 32'hCAFE_0001, 4'h0);
    checkOutput("ovlCh0ValidOr", 32'(validOr), 32'h1);
    checkOutput("ovlCh0Data", gotRdata, 32'hCAFE_0001);
    applyStimulus(32'h0303_0000, 32'h0, 4'h0, 3, 0, 32'h3333_3333, 4'h0);
    checkOutput("ovlCh3ValidOr", 32'(validOr), 32'h8);
    checkOutput("ovlCh3Data", gotRdata, 32'h3333_3333);

    applyStimulus(32'h0500_0000, 32'h0, 4'h0, 0, 100, 32'h0, 4'h0);
    checkOutput("unmapData", gotRdata, 32'hDEAD_BEEF);
    checkOutput("unmapLat", 32'(gotLat), 32'd2);
    checkOutput("unmapValidCnt", 32'(validCount), 32'd0);
    checkOutput("unmapIrq", 32'(err_irq), 32'd1);
    readStatus("statusUnmap", 32'h0500_0001);

    applyStimulus(32'h0302_0000, 32'h0, 4'h0, 2, 100, 32'h0, 4'b1011);
    checkOutput("tmoData", gotRdata, 32'hDEAD_BEEF);
    checkOutput("tmoLat", 32'(gotLat), 32'd10);
    checkOutput("tmoValidCnt", 32'(validCount), 32'd8);
    checkOutput("tmoValidOr", 32'(validOr), 32'h4);
    checkOutput("tmoIrq", 32'(err_irq), 32'd1);
    readStatus("statusTmo", 32'h0302_0002);

    applyStimulus(32'h0400_0000, 32'h1, 4'h1, 0, 100, 32'h0, 4'h0);
    checkOutput("clrLat", 32'(gotLat), 32'd2);
    checkOutput("clrIrq", 32'(err_irq), 32'd0);
    readStatus("statusClr", 32'h0);

    @(negedge clk);
    mem_addr  = 32'h0301_0000;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abortPreValid", 32'(slv_valid), 32'h2);
    mem_valid = 1'b0;
    @(negedge clk);
    checkOutput("abortValid", 32'(slv_valid), 32'h0);
    @(negedge clk);
    checkOutput("abortReady", 32'(mem_ready), 32'd0);
    readStatus("statusAbort", 32'h0);

    applyStimulus(32'h0600_0000, 32'h1111_2222, 4'hF, 0, 100, 32'h0, 4'h0);
    checkOutput("unmapWrData", gotRdata, 32'hDEAD_BEEF);
    checkOutput("unmapWrValidCnt", 32'(validCount), 32'd0);
    readStatus("statusUnmapWr", 32'h0600_0001);

    @(negedge clk);
    mem_addr  = 32'h0302_0000;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstPreValid", 32'(slv_valid), 32'h4);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(slv_valid), 32'h0);
    checkOutput("midRstReady", 32'(mem_ready), 32'd0);
    checkOutput("midRstIrq", 32'(err_irq), 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    applyStimulus(32'h0301_0000, 32'h0, 4'h0, 1, 0, 32'h55AA_55AA, 4'h0);
    checkOutput("postRstData", gotRdata, 32'h55AA_55AA);
    checkOutput("postRstLat", 32'(gotLat), 32'd3);
    checkOutput("postRstValidOr", 32'(validOr), 32'h2);
    readStatus("statusPostRst", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
